// File: rtl/constants_pkg.sv
// -----------------------------------------------------------------------------
// constants_pkg
// Shared types and constants for the peripheral bus fabric.
//   word_t         : bus data word
//   CMD_NOP        : command code meaning "no operation"
//   ERR_*          : response error codes returned to the master
//   router_state_t : bus_router control states
//   request_t      : master request as latched by bus_router
// -----------------------------------------------------------------------------
package constants_pkg;

   typedef logic [15:0] word_t;

   localparam logic [3:0] CMD_NOP     = 4'h0;
   localparam logic [3:0] ERR_NONE    = 4'h0;
   localparam logic [3:0] ERR_BAD_ID  = 4'h1;
   localparam logic [3:0] ERR_TIMEOUT = 4'h2;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_ISSUE,
      READ_WAIT,
      RESP
   } router_state_t;

   typedef struct packed {
      word_t      data;
      logic [3:0] write_id;
      logic [3:0] read_id;
      logic [3:0] write_command;
      logic [3:0] read_command;
   } request_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// -----------------------------------------------------------------------------
// bus_timeout_counter
// Down-counter bounding how long the router waits for a slave read response.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load the counter with TIMEOUT
//   dec        : decrement by one (saturates at zero)
//   expired    : high in the cycle where this decrement takes the count to 0
// -----------------------------------------------------------------------------
module bus_timeout_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(TIMEOUT);
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   // Flagging the 1->0 step lets the router respond on the edge that ends the
   // last waiting cycle, giving exactly TIMEOUT cycles in READ_WAIT.
   assign expired = dec && (count == CNT_W'(1));

endmodule

// File: rtl/bus_router.sv
// -----------------------------------------------------------------------------
// bus_router
// Routes one master transaction at a time (write, read, or write then read) to
// NUM_SLAVES peripheral ports and returns read data or an error to the master.
//   clk, reset        : clock, asynchronous active-high reset
//   m_i_data/m_i_valid: master write data and request strobe (taken when idle)
//   m_write_id/_command, m_read_id/_command : request targets and commands
//   m_o_data/m_o_valid/m_error : one-cycle response to the master
//   m_busy            : transaction in progress
//   s_o_data/s_o_valid/s_command : per-slave command outputs
//   s_i_data/s_i_valid/s_error   : per-slave read responses
// All outputs are registered; data/command/error fields are 0 when their
// strobe is low.
// -----------------------------------------------------------------------------
module bus_router
   import constants_pkg::*;
#(
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  word_t                          m_i_data,
   input  logic                           m_i_valid,
   input  logic [3:0]                     m_write_id,
   input  logic [3:0]                     m_read_id,
   input  logic [3:0]                     m_write_command,
   input  logic [3:0]                     m_read_command,
   output word_t                          m_o_data,
   output logic                           m_o_valid,
   output logic [3:0]                     m_error,
   output logic                           m_busy,
   output word_t [NUM_SLAVES-1:0]         s_o_data,
   output logic  [NUM_SLAVES-1:0]         s_o_valid,
   output logic  [NUM_SLAVES-1:0][3:0]    s_command,
   input  word_t [NUM_SLAVES-1:0]         s_i_data,
   input  logic  [NUM_SLAVES-1:0]         s_i_valid,
   input  logic  [NUM_SLAVES-1:0][3:0]    s_error
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   function automatic logic id_ok(input logic [3:0] id);
      return int'(id) < NUM_SLAVES;
   endfunction

   // Only meaningful after id_ok() has accepted the id.
   function automatic logic [IDX_W-1:0] idx(input logic [3:0] id);
      return id[IDX_W-1:0];
   endfunction

   router_state_t state;
   request_t      req;
   logic          tmo_load;
   logic          tmo_dec;
   logic          tmo_expired;

   assign tmo_load = (state == READ_ISSUE) && id_ok(req.read_id);
   assign tmo_dec  = (state == READ_WAIT);

   bus_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .load    (tmo_load),
      .dec     (tmo_dec),
      .expired (tmo_expired)
   );

   // Slave strobes are registered on the edge that enters WRITE / READ_ISSUE,
   // so the strobe is visible during the cycle named after that state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         req       <= '0;
         m_o_data  <= '0;
         m_o_valid <= 1'b0;
         m_error   <= ERR_NONE;
         m_busy    <= 1'b0;
         s_o_data  <= '0;
         s_o_valid <= '0;
         s_command <= '0;
      end else begin
         // NOTE: every strobe and payload defaults to 0 each cycle; a later
         // non-blocking assignment in the same block overrides the default.
         m_o_data  <= '0;
         m_o_valid <= 1'b0;
         m_error   <= ERR_NONE;
         s_o_data  <= '0;
         s_o_valid <= '0;
         s_command <= '0;

         case (state)
            IDLE: begin
               if (m_i_valid) begin
                  req <= '{data:          m_i_data,
                           write_id:      m_write_id,
                           read_id:       m_read_id,
                           write_command: m_write_command,
                           read_command:  m_read_command};
                  if (m_write_command != CMD_NOP) begin
                     state  <= WRITE;
                     m_busy <= 1'b1;
                     if (id_ok(m_write_id)) begin
                        s_o_valid[idx(m_write_id)] <= 1'b1;
                        s_command[idx(m_write_id)] <= m_write_command;
                        s_o_data[idx(m_write_id)]  <= m_i_data;
                     end
                  end else if (m_read_command != CMD_NOP) begin
                     state  <= READ_ISSUE;
                     m_busy <= 1'b1;
                     if (id_ok(m_read_id)) begin
                        s_o_valid[idx(m_read_id)] <= 1'b1;
                        s_command[idx(m_read_id)] <= m_read_command;
                     end
                  end
               end
            end

            WRITE: begin
               if (!id_ok(req.write_id)) begin
                  // A bad write target cancels the whole request.
                  state     <= RESP;
                  m_o_valid <= 1'b1;
                  m_error   <= ERR_BAD_ID;
               end else if (req.read_command != CMD_NOP) begin
                  state <= READ_ISSUE;
                  if (id_ok(req.read_id)) begin
                     s_o_valid[idx(req.read_id)] <= 1'b1;
                     s_command[idx(req.read_id)] <= req.read_command;
                  end
               end else begin
                  state     <= RESP;
                  m_o_valid <= 1'b1;
               end
            end

            READ_ISSUE: begin
               if (!id_ok(req.read_id)) begin
                  state     <= RESP;
                  m_o_valid <= 1'b1;
                  m_error   <= ERR_BAD_ID;
               end else begin
                  state <= READ_WAIT;
               end
            end

            READ_WAIT: begin
               // A response in the expiring cycle still wins over the timeout.
               if (s_i_valid[idx(req.read_id)]) begin
                  state     <= RESP;
                  m_o_valid <= 1'b1;
                  m_o_data  <= s_i_data[idx(req.read_id)];
                  m_error   <= s_error[idx(req.read_id)];
               end else if (tmo_expired) begin
                  state     <= RESP;
                  m_o_valid <= 1'b1;
                  m_error   <= ERR_TIMEOUT;
               end
            end

            RESP: begin
               state  <= IDLE;
               m_busy <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               m_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_router.sv
// -----------------------------------------------------------------------------
// tb_bus_router
// Directed, table-driven bench for bus_router (NUM_SLAVES=4, TIMEOUT=15).
// Each table row is one master request with the slave behaviour to present and
// the hand-computed cycle offsets (from the request cycle N) of the expected
// write strobe, read strobe and master response.
// -----------------------------------------------------------------------------
module tb_bus_router;
   import constants_pkg::*;

   localparam int NS  = 4;
   localparam int WIN = 20;

   logic                    clk;
   logic                    reset;
   word_t                   m_i_data;
   logic                    m_i_valid;
   logic [3:0]              m_write_id;
   logic [3:0]              m_read_id;
   logic [3:0]              m_write_command;
   logic [3:0]              m_read_command;
   word_t                   m_o_data;
   logic                    m_o_valid;
   logic [3:0]              m_error;
   logic                    m_busy;
   word_t [NS-1:0]          s_o_data;
   logic  [NS-1:0]          s_o_valid;
   logic  [NS-1:0][3:0]     s_command;
   word_t [NS-1:0]          s_i_data;
   logic  [NS-1:0]          s_i_valid;
   logic  [NS-1:0][3:0]     s_error;

   bus_router #(
      .NUM_SLAVES (NS),
      .TIMEOUT    (15)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .m_i_data        (m_i_data),
      .m_i_valid       (m_i_valid),
      .m_write_id      (m_write_id),
      .m_read_id       (m_read_id),
      .m_write_command (m_write_command),
      .m_read_command  (m_read_command),
      .m_o_data        (m_o_data),
      .m_o_valid       (m_o_valid),
      .m_error         (m_error),
      .m_busy          (m_busy),
      .s_o_data        (s_o_data),
      .s_o_valid       (s_o_valid),
      .s_command       (s_command),
      .s_i_data        (s_i_data),
      .s_i_valid       (s_i_valid),
      .s_error         (s_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] wcmd;
      logic [3:0] wid;
      logic [3:0] rcmd;
      logic [3:0] rid;
      word_t      data;
      int         k;        // slave answers k cycles after the read strobe (0 = silent)
      word_t      rdata;
      logic [3:0] serr;
      int         noise_t;  // cycle with a stray s_i_valid from another slave (0 = none)
      int         drop_t;   // cycle with an extra m_i_valid while busy (0 = none)
      int         ws;       // expected write strobe cycle (0 = none)
      int         rs;       // expected read strobe cycle (0 = none)
      int         resp;     // expected m_o_valid cycle (0 = none)
      word_t      edata;
      logic [3:0] eerr;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m_i_valid       = 1'b0;
      m_i_data        = '0;
      m_write_id      = '0;
      m_read_id       = '0;
      m_write_command = CMD_NOP;
      m_read_command  = CMD_NOP;
      s_i_valid       = '0;
      s_i_data        = '0;
      s_error         = '0;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      logic  [NS-1:0]      esv;
      logic  [NS-1:0][3:0] esc;
      word_t [NS-1:0]      esd;
      logic  [20:0]        exp_m;
      logic  [1:0]         ri;
      logic  [1:0]         wi;
      ri = v.rid[1:0];
      wi = v.wid[1:0];

      @(posedge clk); #1;
      m_i_valid       = 1'b1;
      m_i_data        = v.data;
      m_write_id      = v.wid;
      m_read_id       = v.rid;
      m_write_command = v.wcmd;
      m_read_command  = v.rcmd;

      for (int t = 1; t <= WIN; t++) begin
         @(posedge clk); #1;
         m_i_valid = (t == v.drop_t);
         s_i_valid = '0;
         for (int i = 0; i < NS; i++) begin
            s_i_data[i] = 16'hDEAD;
            s_error[i]  = 4'hF;
         end
         if (v.rid < NS) begin
            s_i_data[ri] = v.rdata;
            s_error[ri]  = v.serr;
         end
         if (v.k > 0 && v.rs > 0 && t == v.rs + v.k) s_i_valid[ri] = 1'b1;
         if (t == v.noise_t) s_i_valid[ri + 2'd1] = 1'b1;

         @(negedge clk);
         esv = '0;
         esc = '0;
         esd = '0;
         if (t == v.ws) begin
            esv[wi] = 1'b1;
            esc[wi] = v.wcmd;
            esd[wi] = v.data;
         end
         if (t == v.rs) begin
            esv[ri] = 1'b1;
            esc[ri] = v.rcmd;
         end
         exp_m = (t == v.resp) ? {1'b1, v.edata, v.eerr} : 21'd0;

         check($sformatf("v%0d t%0d slave_out", n, t),
               {s_o_valid, s_command, s_o_data}, {esv, esc, esd});
         check($sformatf("v%0d t%0d master_resp", n, t),
               {m_o_valid, m_o_data, m_error}, exp_m);
         check($sformatf("v%0d t%0d busy", n, t),
               m_busy, (v.resp != 0 && t <= v.resp));
      end
      idle_inputs();
   endtask

   vec_t vecs[10];

   initial begin
      int seen;

      //            wcmd  wid   rcmd  rid   data      k   rdata     serr  nz dr ws rs resp edata     eerr
      vecs[0] = '{4'h3, 4'h2, 4'h0, 4'h0, 16'hBEEF, 0,  16'h0000, 4'h0, 0, 0, 1, 0, 2,  16'h0000, 4'h0};
      vecs[1] = '{4'h0, 4'h0, 4'h5, 4'h1, 16'h0000, 3,  16'h1234, 4'h0, 0, 0, 0, 1, 5,  16'h1234, 4'h0};
      vecs[2] = '{4'h3, 4'h0, 4'h5, 4'h3, 16'hA5A5, 1,  16'h5678, 4'h0, 0, 0, 1, 2, 4,  16'h5678, 4'h0};
      vecs[3] = '{4'h0, 4'h0, 4'h5, 4'h5, 16'h0000, 0,  16'h0000, 4'h0, 0, 0, 0, 0, 2,  16'h0000, 4'h1};
      vecs[4] = '{4'h3, 4'h7, 4'h5, 4'h1, 16'h1111, 0,  16'h0000, 4'h0, 0, 0, 0, 0, 2,  16'h0000, 4'h1};
      vecs[5] = '{4'h0, 4'h0, 4'h5, 4'h2, 16'h0000, 0,  16'h0000, 4'h0, 0, 3, 0, 1, 17, 16'h0000, 4'h2};
      vecs[6] = '{4'h0, 4'h0, 4'h0, 4'h0, 16'h7777, 0,  16'h0000, 4'h0, 0, 0, 0, 0, 0,  16'h0000, 4'h0};
      vecs[7] = '{4'h0, 4'h0, 4'h6, 4'h0, 16'h0000, 2,  16'h0BAD, 4'h7, 2, 0, 0, 1, 4,  16'h0BAD, 4'h7};
      vecs[8] = '{4'h0, 4'h0, 4'h5, 4'h3, 16'h0000, 15, 16'h4321, 4'h0, 0, 0, 0, 1, 17, 16'h4321, 4'h0};
      vecs[9] = '{4'h0, 4'h0, 4'h5, 4'h3, 16'h0000, 16, 16'h4321, 4'h0, 0, 0, 0, 1, 17, 16'h0000, 4'h2};

      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state",
            {m_o_valid, m_o_data, m_error, m_busy, s_o_valid, s_command, s_o_data}, '0);
      reset = 1'b0;

      for (int n = 0; n < 10; n++) run_vec(n, vecs[n]);

      // Reset asserted while waiting on a silent slave aborts without a response.
      @(posedge clk); #1;
      m_i_valid      = 1'b1;
      m_read_id      = 4'h1;
      m_read_command = 4'h5;
      @(posedge clk); #1;
      idle_inputs();
      repeat (4) @(posedge clk);
      #3;
      check("busy_before_reset", m_busy, 1'b1);
      reset = 1'b1;
      #1;
      check("reset_abort_outputs",
            {m_o_valid, m_o_data, m_error, m_busy, s_o_valid, s_command, s_o_data}, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      seen = 0;
      for (int t = 0; t < WIN; t++) begin
         @(negedge clk);
         if (m_o_valid || m_busy) seen++;
      end
      check("no_activity_after_abort", seen, 0);

      run_vec(10, vecs[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_router.md
Name: bus_router

Overview:
- Sits between the CPU-side master bus (master_bus_if signal set) and NUM_SLAVES peripheral ports (bus_if signal set).
- Accepts one master transaction at a time, which may be a write, a read, or a write followed by a read.
- Routes the write to slave `write_id` and issues the read to slave `read_id`, then returns the read data or an error code to the master.
- Times out reads whose slave never answers.

Parameters:
NUM_SLAVES, 4, number of slave ports; ids 0..NUM_SLAVES-1 valid (max 16)
TIMEOUT, 15, cycles to wait for slave i_valid before erroring (1..255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_i_data  in  word_t  master write data
m_i_valid  in  1  master request strobe, sampled only when m_busy=0
m_write_id  in  4  target slave of write
m_read_id  in  4  target slave of read
m_write_command  in  4  write command; CMD_NOP (4'h0) = no write
m_read_command  in  4  read command; CMD_NOP = no read
m_o_data  out  word_t  read data returned to master
m_o_valid  out  1  one-cycle response strobe
m_error  out  4  response error code, valid with m_o_valid
m_busy  out  1  transaction in progress
s_o_data  out  NUM_SLAVES x word_t  data to each slave
s_o_valid  out  NUM_SLAVES  per-slave command strobe
s_command  out  NUM_SLAVES x 4  per-slave command
s_i_data  in  NUM_SLAVES x word_t  slave read data
s_i_valid  in  NUM_SLAVES  slave response strobe
s_error  in  NUM_SLAVES x 4  slave error, sampled with s_i_valid

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; latched request cleared. Reset mid-transaction aborts it silently with no m_o_valid.
- States: IDLE, WRITE, READ_ISSUE, READ_WAIT, RESP.
- IDLE:
  - m_busy=0.
  - On m_i_valid, latch all master inputs and set m_busy=1 on the next cycle.
  - If both commands are NOP, stay in IDLE (request ignored, no response).
  - If the write command is non-NOP, go to WRITE; otherwise go to READ_ISSUE.
- WRITE (1 cycle):
  - If write_id < NUM_SLAVES, drive s_o_valid[write_id]=1, s_command=write_command, s_o_data=latched data.
  - Else raise ERR_BAD_ID (4'h1), skip any read, and go to RESP.
  - On success, go to READ_ISSUE if the read command is non-NOP; else go to RESP with error 0 and m_o_data=0.
- READ_ISSUE (1 cycle):
  - If read_id is invalid, go to RESP with ERR_BAD_ID.
  - Else strobe s_o_valid[read_id] with s_command=read_command and s_o_data=0, load the timeout counter with TIMEOUT, and go to READ_WAIT.
- READ_WAIT:
  - s_i_valid from slave read_id captures s_i_data and s_error, then goes to RESP.
  - Otherwise the counter decrements; reaching 0 gives ERR_TIMEOUT (4'h2), m_o_data=0, and goes to RESP.
  - If s_i_valid arrives in the same cycle the counter hits 0, the data wins.
  - s_i_valid from any other slave is ignored.
- RESP (1 cycle): m_o_valid=1 with latched m_o_data/m_error; return to IDLE, where m_busy=0 the next cycle.
- Latency from the m_i_valid cycle N:
  - Pure write: slave strobe at N+1, m_o_valid at N+2.
  - Read with a slave answering k cycles after its strobe: strobe at N+1, m_o_valid at N+2+k.
  - Write+read: write strobe N+1, read strobe N+2.
- Response rules:
  - Every accepted non-NOP request yields exactly one m_o_valid.
  - m_o_data, m_error and s_* outputs are 0 whenever their valid is low.
  - m_i_valid while m_busy=1 is dropped.
- Registers: s_* outputs are registered; all outputs are driven from registers.

Decomposition:
- constants_pkg gains: CMD_NOP, ERR_NONE, ERR_BAD_ID, ERR_TIMEOUT, and router_state_t enum.
- word_t is already in constants_pkg.
- One sub-module, bus_timeout_counter: load/decrement/expired, width $clog2(TIMEOUT+1).

Test Plan:
- Write 16'hBEEF, id 2, cmd 4'h3 -> s_o_valid[2] high only at N+1 with s_o_data=BEEF, s_command=3; m_o_valid at N+2 with error 0.
- Read id 1, cmd 4'h5, slave returns 16'h1234 after 3 cycles -> strobe at N+1, m_o_valid at N+5 with data 1234, error 0; m_busy high N+1..N+5.
- Write id 0 then read id 3 in one request -> s_o_valid[0] at N+1, s_o_valid[3] at N+2, response carries slave 3 data.
- Read id 5 with NUM_SLAVES=4 -> no slave strobe; m_o_valid with m_error=4'h1; write id 7 plus read -> ERR_BAD_ID, read not issued.
- Silent slave, TIMEOUT=15 -> m_o_valid at N+17 with m_error=4'h2; a second m_i_valid pulsed at N+3 produces no extra response.
- Assert reset during READ_WAIT -> all outputs 0 immediately; no m_o_valid; a new read after release completes normally.
